// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic       AN_OFF  = 1'b1;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_if.sv
// Display-side bundle: scan tick and frame inputs in, anode/segment drive out.
// The DUT takes the slave view; whoever supplies digits and watches the pins takes master.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    segclk;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output segclk, value, dp_mask, blank_mask,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  segclk, value, dp_mask, blank_mask,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low seven-segment pattern; purely combinational, no handshake.
module seg_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_hex];

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment scanner: one digit per segclk tick, blank gap between digits.
// Outputs registered, 1 clk behind the state that selects them; no backpressure, ticks during BLANK are dropped.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16
) (
  input logic      clk,
  input logic      clr_n,
  seg_scan_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_segclk_q;
  logic                    w_tick;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_inc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_blank_done;
  logic                    w_snap;
  logic [4*NUM_DIGITS-1:0] r_frame_value;
  logic [NUM_DIGITS-1:0]   r_frame_dp;
  logic [NUM_DIGITS-1:0]   r_frame_blank;
  logic                    r_frame_start;
  logic [3:0]              w_digit;
  logic [6:0]              w_digit_seg;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;

  // segclk is a slow level from the divider; only its rising edge matters here.
  assign w_tick       = bus.segclk & ~r_segclk_q;
  assign w_blank_done = (BLANK_CYCLES == 0) || (r_cnt == CNT_LAST);
  assign w_idx_inc    = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
  assign w_snap       = w_tick && ((r_state == IDLE) || ((r_state == DRIVE) && (r_idx == IDX_LAST)));
  assign w_digit      = r_frame_value[{r_idx, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .i_hex (w_digit),
    .o_seg (w_digit_seg)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_segclk_q <= 1'b1;
      r_state    <= IDLE;
    end else begin
      r_segclk_q <= bus.segclk;
      r_state    <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_tick)       w_state_nxt = BLANK;
      BLANK:   if (w_blank_done) w_state_nxt = DRIVE;
      DRIVE:   if (w_tick)       w_state_nxt = BLANK;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_idx         <= '0;
      r_cnt         <= '0;
      r_frame_value <= '0;
      r_frame_dp    <= '0;
      r_frame_blank <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_snap;
      r_cnt         <= (r_state == BLANK) ? r_cnt + 1'b1 : '0;
      if ((r_state == IDLE) && w_tick) begin
        r_idx <= '0;
      end else if ((r_state == DRIVE) && w_tick) begin
        r_idx <= w_idx_inc;
      end
      // Frame registers only move at digit 0 so a half-scanned value never tears.
      if (w_snap) begin
        r_frame_value <= bus.value;
        r_frame_dp    <= bus.dp_mask;
        r_frame_blank <= bus.blank_mask;
      end
    end
  end

  always_comb begin
    w_an_nxt  = {NUM_DIGITS{AN_OFF}};
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = 1'b1;
    if ((r_state == DRIVE) && !r_frame_blank[r_idx]) begin
      w_an_nxt[r_idx] = ~AN_OFF;
      w_seg_nxt       = w_digit_seg;
      w_dp_nxt        = ~r_frame_dp[r_idx];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_an  <= {NUM_DIGITS{AN_OFF}};
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign bus.an          = r_an;
  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: two instances (16-clk and zero blank) driven in lockstep, checked
// every cycle against a display-timeline model plus directed spot checks.
module tb_seg_scan;

  localparam int BLANK_A = 16;
  localparam int BLANK_B = 0;
  localparam logic [11:0] OFF = {4'hF, 7'h7F, 1'b1};
  localparam logic [6:0] TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk;
  logic        clr_n;
  logic        segclk;
  logic [15:0] value;
  logic [3:0]  dp_m;
  logic [3:0]  bl_m;

  int checks;
  int errors;
  bit mon_en;

  seg_scan_if #(.NUM_DIGITS(4)) if_a ();
  seg_scan_if #(.NUM_DIGITS(4)) if_b ();

  assign if_a.segclk     = segclk;
  assign if_a.value      = value;
  assign if_a.dp_mask    = dp_m;
  assign if_a.blank_mask = bl_m;
  assign if_b.segclk     = segclk;
  assign if_b.value      = value;
  assign if_b.dp_mask    = dp_m;
  assign if_b.blank_mask = bl_m;

  seg_scan #(.NUM_DIGITS(4), .BLANK_CYCLES(BLANK_A)) dut_a (.clk(clk), .clr_n(clr_n), .bus(if_a));
  seg_scan #(.NUM_DIGITS(4), .BLANK_CYCLES(BLANK_B)) dut_b (.clk(clk), .clr_n(clr_n), .bus(if_b));

  logic [3:0] o_an [2];
  logic [6:0] o_seg [2];
  logic       o_dp [2];
  logic       o_fs [2];
  assign o_an[0] = if_a.an;   assign o_seg[0] = if_a.seg;
  assign o_dp[0] = if_a.dp;   assign o_fs[0]  = if_a.frame_start;
  assign o_an[1] = if_b.an;   assign o_seg[1] = if_b.seg;
  assign o_dp[1] = if_b.dp;   assign o_fs[1]  = if_b.frame_start;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int gap_of(input int d);
    int b;
    b = (d == 0) ? BLANK_A : BLANK_B;
    return (b == 0) ? 1 : b;
  endfunction

  // What the pins show while a digit is being driven: {an, seg, dp}.
  function automatic logic [11:0] disp(input int slot, input logic [15:0] v,
                                       input logic [3:0] dpm, input logic [3:0] blm);
    logic [3:0] an;
    logic [3:0] h;
    if (blm[slot]) return OFF;
    an = 4'hF;
    an[slot] = 1'b0;
    h = v[slot*4 +: 4];
    return {an, TBL[h], ~dpm[slot]};
  endfunction

  // Timeline model: after an accepted tick the old digit lingers one sample, the pins
  // are dark for the gap, then the new digit shows; ticks inside the gap are ignored.
  bit          seg_prev;
  bit          m_act [2];
  int          m_j [2];
  int          m_slot [2];
  logic [15:0] m_fval [2];
  logic [3:0]  m_fdp [2];
  logic [3:0]  m_fbl [2];
  logic [11:0] m_cur [2];
  logic [11:0] m_prev [2];
  bit          m_fs [2];

  task automatic model_step();
    bit acc;
    if (!clr_n) begin
      seg_prev = 1'b1;
      for (int d = 0; d < 2; d++) begin
        m_act[d] = 0; m_j[d] = 0; m_slot[d] = 0;
        m_cur[d] = OFF; m_prev[d] = OFF; m_fs[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        acc = segclk && !seg_prev && (!m_act[d] || m_j[d] >= gap_of(d));
        m_fs[d] = 0;
        if (acc) begin
          m_slot[d] = m_act[d] ? (m_slot[d] + 1) % 4 : 0;
          m_act[d] = 1;
          if (m_slot[d] == 0) begin
            m_fval[d] = value; m_fdp[d] = dp_m; m_fbl[d] = bl_m; m_fs[d] = 1;
          end
          m_prev[d] = m_cur[d];
          m_cur[d]  = disp(m_slot[d], m_fval[d], m_fdp[d], m_fbl[d]);
          m_j[d]    = 0;
        end else if (m_j[d] < 100000) begin
          m_j[d]++;
        end
      end
      seg_prev = segclk;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge clr_n);
      model_step();
    end
  end

  initial begin
    logic [11:0] e;
    bit          efs;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          if (m_j[d] == 0) begin
            e = m_prev[d]; efs = m_fs[d];
          end else if (m_j[d] <= gap_of(d)) begin
            e = OFF; efs = 1'b0;
          end else begin
            e = m_cur[d]; efs = 1'b0;
          end
          chk(d == 0 ? "mon_disp_a" : "mon_disp_b", {o_an[d], o_seg[d], o_dp[d]}, e);
          chk(d == 0 ? "mon_fs_a" : "mon_fs_b", 12'(o_fs[d]), 12'(efs));
        end
      end
    end
  end

  task automatic tick(input int hi, input int lo);
    segclk = 1'b1;
    repeat (hi) @(negedge clk);
    segclk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic chk_digit(input string tag, input logic [3:0] an, input logic [6:0] seg);
    chk({tag, "_an"}, 12'(o_an[0]), 12'(an));
    chk({tag, "_seg"}, 12'(o_seg[0]), 12'(seg));
  endtask

  initial begin
    int         gap [2];
    bit         seen [2];
    bit         done [2];
    logic [3:0] h;
    checks = 0; errors = 0; mon_en = 0;
    clr_n = 1'b0; segclk = 1'b1; value = '0; dp_m = '0; bl_m = '0;

    // Reset values, then release with segclk already high: no tick may result.
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_disp", {o_an[d], o_seg[d], o_dp[d]}, OFF);
      chk("rst_fs", 12'(o_fs[d]), 12'h0);
    end
    @(negedge clk);
    #2 clr_n = 1'b1;
    mon_en = 1;
    repeat (20) @(negedge clk);
    chk("idle_an", 12'(o_an[0]), 12'hF);
    segclk = 1'b0;
    @(negedge clk);

    // Plain scan of 1234, then tearing check with ABCD written while digit 1 is up.
    value = 16'h1234;
    segclk = 1'b1;
    @(negedge clk);
    chk("first_fs_a", 12'(o_fs[0]), 12'h1);
    chk("first_fs_b", 12'(o_fs[1]), 12'h1);
    repeat (2) @(negedge clk);
    segclk = 1'b0;
    repeat (27) @(negedge clk);
    chk_digit("dig0_4", 4'b1110, 7'b0011001);
    tick(3, 27);
    chk_digit("dig1_3", 4'b1101, 7'b0110000);
    value = 16'hABCD;
    tick(3, 27);
    chk_digit("tear_dig2", 4'b1011, 7'b0100100);
    tick(3, 27);
    chk_digit("tear_dig3", 4'b0111, 7'b1111001);
    tick(3, 27);
    chk_digit("new_dig0_d", 4'b1110, 7'b0100001);
    tick(3, 27);
    chk_digit("new_dig1_C", 4'b1101, 7'b1000110);

    // Masks take effect only from the next frame.
    bl_m = 4'b1000; dp_m = 4'b0001;
    tick(3, 27);
    tick(3, 27);
    chk("old_frame_dig3_an", 12'(o_an[0]), 12'(4'b0111));
    tick(3, 27);
    chk("dp_dig0", 12'(o_dp[0]), 12'h0);
    tick(3, 27);
    chk("dp_dig1", 12'(o_dp[0]), 12'h1);
    tick(3, 27);
    tick(3, 27);
    chk("blank_dig3", {o_an[0], o_seg[0], o_dp[0]}, OFF);
    tick(3, 27);

    // Dark interval between digit 0 and digit 1 on both instances.
    for (int d = 0; d < 2; d++) begin gap[d] = 0; seen[d] = 0; done[d] = 0; end
    segclk = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 3) segclk = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (o_an[d] == 4'hF) begin
          if (!done[d]) begin seen[d] = 1; gap[d]++; end
        end else if (seen[d]) begin
          done[d] = 1;
        end
      end
    end
    chk("gap_a", done[0] ? 12'(gap[0]) : 12'hFFF, 12'(gap_of(0)));
    chk("gap_b", done[1] ? 12'(gap[1]) : 12'hFFF, 12'(gap_of(1)));

    // Async reset in the middle of a digit, then a fresh frame.
    #2 clr_n = 1'b0;
    #1;
    chk("async_rst_a", {o_an[0], o_seg[0], o_dp[0]}, OFF);
    chk("async_rst_b", {o_an[1], o_seg[1], o_dp[1]}, OFF);
    @(negedge clk);
    #2 clr_n = 1'b1;
    value = 16'($urandom); bl_m = '0; dp_m = '0;
    @(negedge clk);
    segclk = 1'b1;
    @(negedge clk);
    chk("restart_fs", 12'(o_fs[0]), 12'h1);
    repeat (2) @(negedge clk);
    segclk = 1'b0;
    repeat (27) @(negedge clk);
    h = value[3:0];
    chk_digit("restart_dig0", 4'b1110, TBL[h]);

    // Random ticks, some landing inside the gap, with inputs changing mid-frame.
    repeat (120) begin
      value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        dp_m = 4'($urandom);
        bl_m = 4'($urandom);
      end
      tick($urandom_range(1, 10), $urandom_range(1, 24));
    end

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
